// File: rtl/neuron_mac.sv
// rtl/neuron_mac.sv - fixed-point neuron: multiply-accumulate, bias, saturate, optional tanh

// neuron_tanh - odd-symmetric piecewise-linear tanh on Q(WIDTH-FRAC).FRAC operands
module neuron_tanh #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  // One extra bit so the magnitude of the most negative input is representable.
  localparam int MW = WIDTH + 1;

  localparam logic signed [MW-1:0] ONE   = MW'(1) << FRAC;
  localparam logic signed [MW-1:0] TWO   = ONE <<< 1;
  localparam logic signed [MW-1:0] THREE = ONE + TWO;
  localparam logic signed [MW-1:0] BASE1 = (ONE >>> 1) + (ONE >>> 2);
  localparam logic signed [MW-1:0] BASE2 = BASE1 + (ONE >>> 3) + (ONE >>> 4);

  logic signed [MW-1:0] xe;
  logic signed [MW-1:0] mag;
  logic signed [MW-1:0] res;

  // Segments: slope 3/4 below 1.0, 3/16 up to 2.0, 1/16 up to 3.0, then 1.0.
  always_comb begin
    xe  = {x[WIDTH-1], x};
    mag = x[WIDTH-1] ? -xe : xe;
    res = ONE;
    if (mag < ONE) begin
      res = (mag >>> 1) + (mag >>> 2);
    end else if (mag < TWO) begin
      res = BASE1 + ((mag - ONE) >>> 3) + ((mag - ONE) >>> 4);
    end else if (mag < THREE) begin
      res = BASE2 + ((mag - TWO) >>> 4);
    end
    y = x[WIDTH-1] ? WIDTH'(-res) : WIDTH'(res);
  end

endmodule

// neuron_mac - accumulates N_IN products, adds bias, saturates, applies activation
module neuron_mac #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16,
  parameter int N_IN  = 3,
  parameter int ACT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] w,
  output logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             sat
);

  localparam int CW    = $clog2(N_IN + 1);
  localparam int PW    = 2 * WIDTH;
  localparam int ACC_W = PW + CW;
  localparam int PRE_W = ACC_W + 1;

  localparam logic signed [PRE_W-1:0] MAXV = {{(PRE_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PRE_W-1:0] MINV = {{(PRE_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]           LAST = CW'(N_IN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_FINAL,
    S_OUT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic signed [ACC_W-1:0] acc;
  logic [CW-1:0]           cnt;
  logic [WIDTH-1:0]        b_q;
  logic [WIDTH-1:0]        y_q;
  logic                    sat_q;

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_shift;
  logic signed [PRE_W-1:0] pre;
  logic [WIDTH-1:0]        pre_sat;
  logic                    pre_clamp;
  logic [WIDTH-1:0]        act_out;

  logic                    accept;
  logic                    last_pair;

  // Operands are sign-extended to full product width so the low 2*WIDTH bits are exact.
  assign prod     = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{w[WIDTH-1]}}, w});
  assign prod_ext = {{CW{prod[PW-1]}}, prod};

  assign accept    = (state == S_ACCUM) && in_valid;
  assign last_pair = (cnt == LAST);

  // Rescale the accumulator to result format (floor), add bias, clamp to WIDTH range.
  always_comb begin
    acc_shift = acc >>> FRAC;
    pre       = {acc_shift[ACC_W-1], acc_shift} + {{(PRE_W-WIDTH){b_q[WIDTH-1]}}, b_q};
    pre_sat   = pre[WIDTH-1:0];
    pre_clamp = 1'b0;
    if (pre > MAXV) begin
      pre_sat   = MAXV[WIDTH-1:0];
      pre_clamp = 1'b1;
    end else if (pre < MINV) begin
      pre_sat   = MINV[WIDTH-1:0];
      pre_clamp = 1'b1;
    end
  end

  generate
    if (ACT == 1) begin : g_tanh
      neuron_tanh #(
        .WIDTH(WIDTH),
        .FRAC (FRAC)
      ) u_tanh (
        .x(pre_sat),
        .y(act_out)
      );
    end else begin : g_ident
      assign act_out = pre_sat;
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ACCUM;
      S_ACCUM: if (accept && last_pair) state_nxt = S_FINAL;
      S_FINAL: state_nxt = S_OUT;
      S_OUT:   if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: bias capture, accumulation, and registering of the final result.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      cnt   <= '0;
      b_q   <= '0;
      y_q   <= '0;
      sat_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            b_q <= b;
            acc <= '0;
            cnt <= '0;
          end
        end
        S_ACCUM: begin
          if (accept) begin
            acc <= acc + prod_ext;
            cnt <= cnt + 1'b1;
          end
        end
        S_FINAL: begin
          y_q   <= act_out;
          sat_q <= pre_clamp;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == S_ACCUM);
  assign out_valid = (state == S_OUT);
  assign busy      = (state != S_IDLE);
  assign y         = y_q;
  assign sat       = sat_q;

endmodule

// File: doc/neuron_mac.md
NEURON_MAC -- requirements
Module: neuron_mac

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of all operands and result (signed two's complement).
REQ-002 SHALL have parameter FRAC, default 16, number of fractional bits (Q(WIDTH-FRAC).FRAC fixed point).
REQ-003 SHALL have parameter N_IN, default 3, number of (activation, weight) pairs per neuron evaluation; legal range 1..256.
REQ-004 SHALL have parameter ACT, default 1, activation select: 0 = identity, 1 = existing tanh unit.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port start  input  1  begin a new evaluation; honoured only in IDLE.
REQ-008 SHALL have port b  input  WIDTH  bias, captured on accepted start.
REQ-009 SHALL have port in_valid  input  1  a/w pair valid.
REQ-010 SHALL have port in_ready  output  1  pair accepted when in_valid && in_ready.
REQ-011 SHALL have port a  input  WIDTH  activation operand.
REQ-012 SHALL have port w  input  WIDTH  weight operand.
REQ-013 SHALL have port y  output  WIDTH  neuron result, registered.
REQ-014 SHALL have port out_valid  output  1  y valid.
REQ-015 SHALL have port out_ready  input  1  consumer accepts y when out_valid && out_ready.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.
REQ-017 SHALL have port sat  output  1  pre-activation saturated in current result; valid with out_valid.

Function
REQ-018 SHALL implement FSM IDLE -> ACCUM -> FINAL -> OUT -> IDLE.
REQ-019 IDLE: on start=1, SHALL latch b, clear accumulator and pair counter, go to ACCUM next cycle.
REQ-020 ACCUM: in_ready SHALL be 1; each accepted pair adds full-precision product a*w (2*WIDTH bits) to accumulator of 2*WIDTH+ceil(log2(N_IN+1)) bits; no intermediate truncation.
REQ-021 ACCUM: on acceptance of the N_IN-th pair SHALL go to FINAL; in_valid=0 cycles stall without state change.
REQ-022 in_ready SHALL be 0 in IDLE, FINAL and OUT; in_valid outside ACCUM ignored.
REQ-023 FINAL (one cycle): pre = (acc >>> FRAC) + sign-extended b, arithmetic shift (floor toward -inf); pre saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; sat=1 iff clamped.
REQ-024 FINAL: y SHALL register ACT ? tanh(pre_sat) : pre_sat; go to OUT.
REQ-025 OUT: out_valid=1; y and sat held stable until out_ready=1, then IDLE next cycle with out_valid=0.
REQ-026 Latency: out_valid SHALL rise exactly 2 cycles after the clock edge accepting the last pair.
REQ-027 start while busy=1 SHALL be ignored (no bias recapture, no restart).
REQ-028 start asserted in the cycle OUT returns to IDLE SHALL be ignored; start is sampled only while in IDLE.
REQ-029 N_IN=1: FSM SHALL leave ACCUM after a single accepted pair.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE, accumulator=0, counter=0, y=0, sat=0, out_valid=0, in_ready=0, busy=0, regardless of state.
REQ-031 rst mid-evaluation SHALL discard partial sums; no out_valid pulse follows.
REQ-032 rst SHALL take priority over start, in_valid and out_ready in the same cycle.

Verification (WIDTH=32, FRAC=16, N_IN=3, ACT=0 unless stated)
REQ-033 start,b=0x00008000; 3 pairs a=0x00010000,w=0x00020000 back-to-back; out_ready=1 -> y=0x00068000 (6.5), sat=0, out_valid 2 cycles after 3rd pair.
REQ-034 a=0xFFFF0000,w=0x00008000 x3, b=0 -> y=0xFFFE8000 (-1.5), sat=0; in_valid gaps of 2 cycles between pairs -> same result, in_ready held 1.
REQ-035 a=w=0x7FFF0000 x3, b=0 -> y=0x7FFFFFFF, sat=1; a=0x7FFF0000,w=0x80000000 x3 -> y=0x80000000, sat=1.
REQ-036 out_ready=0 for 5 cycles in OUT -> y, sat, out_valid stable, in_ready=0; start pulsed during OUT ignored; out_ready=1 -> IDLE next cycle.
REQ-037 rst asserted after 2nd accepted pair -> all outputs 0 next cycle; new evaluation from REQ-033 stimulus -> y=0x00068000.
REQ-038 ACT=1: pairs summing to pre=0 with b=0 -> y=0x00000000; compare other results against the tanh unit's direct output for the same pre.
